// File: rtl/mem_pkg.sv
// Shared memory-access definitions for the data-memory responder
// and the core datapath (access sizes, responder states, helpers).
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of bytes touched by an access; 0 marks the illegal size.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Natural alignment check for half and word accesses.
  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) ||
           ((sz == SZ_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian byte-lane steering: extracts/extends load data from an
// aligned word and builds per-byte store enables and store data.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] raw_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half; offset 0 is the most significant byte.
  always_comb begin
    byte_sel = raw_i[7:0];
    case (off_i)
      2'd0:    byte_sel = raw_i[31:24];
      2'd1:    byte_sel = raw_i[23:16];
      2'd2:    byte_sel = raw_i[15:8];
      default: byte_sel = raw_i[7:0];
    endcase
    half_sel = off_i[1] ? raw_i[15:0] : raw_i[31:16];
  end

  // Right-justify and extend the load result.
  always_comb begin
    load_o = raw_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{sgn_i & half_sel[15]}}, half_sel};
      default: load_o = raw_i;
    endcase
  end

  // Store enables (bit i = byte offset i) and replicated store data.
  always_comb begin
    be_o = 4'b0000;
    wd_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o = 4'b0001 << off_i;
        wd_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o = off_i[1] ? 4'b1100 : 4'b0011;
        wd_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        be_o = 4'b1111;
        wd_o = wdata_i;
      end
      default: begin
        be_o = 4'b0000;
        wd_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Stallable byte-addressed data memory behind a valid/ready handshake,
// with configurable wait states between acceptance and response.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [7:0] mem_q [DEPTH];

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        cur_wr;
  logic [1:0]  cur_size;
  logic        cur_sgn;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [AW-3:0] widx;
  logic [32:0]   end_d;
  logic [31:0]   raw_d;
  logic [31:0]   load_d;
  logic [3:0]    be_d;
  logic [31:0]   wd_d;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic          enter_resp;
  logic          commit;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // The executing request comes straight from the port when a
  // zero-wait access enters RESP on its accepting edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_wr    = req_write;
      cur_size  = req_size;
      cur_sgn   = req_signed;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_wr    = wr_q;
      cur_size  = size_q;
      cur_sgn   = sgn_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  // Error detection and aligned-word read for the executing request.
  always_comb begin
    widx  = cur_addr[AW-1:2];
    end_d = {1'b0, cur_addr} + 33'(size_bytes(cur_size));
    err_d = (size_bytes(cur_size) == 3'd0) ||
            misaligned(cur_size, cur_addr[1:0]) ||
            (end_d > 33'(DEPTH));
    raw_d = {mem_q[{widx, 2'd0}], mem_q[{widx, 2'd1}],
             mem_q[{widx, 2'd2}], mem_q[{widx, 2'd3}]};
  end

  byte_lane_align u_align (
    .size_i  (cur_size),
    .sgn_i   (cur_sgn),
    .off_i   (cur_addr[1:0]),
    .raw_i   (raw_d),
    .wdata_i (cur_wdata),
    .load_o  (load_d),
    .be_o    (be_d),
    .wd_o    (wd_d)
  );

  // Response data and the edge on which the access takes effect.
  always_comb begin
    rdata_d    = (err_d || cur_wr) ? 32'd0 : load_d;
    enter_resp = ((state_q == ST_IDLE) && req_valid &&
                  (WAIT_CYCLES == 0)) ||
                 ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    commit     = enter_resp && cur_wr && !err_d && !rst;
  end

  // Store commit into the byte array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) begin
          mem_q[{widx, 2'(i)}] <= wd_d[8*(3-i) +: 8];
        end
      end
    end
  end

  // Handshake FSM with wait counter, request latches and response regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            size_q      <= req_size;
            sgn_q       <= req_signed;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1, 4 wait states)
// checked against a byte-array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_write;
  logic [1:0]  req_size [3];
  logic [2:0]  req_signed;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  logic [7:0] mm [3][1024];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH       (1024),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_size   (req_size[g]),
      .req_signed (req_signed[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 4;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: big-endian byte array, datum's MSB at the lowest address.
  task automatic model(int k, logic wr, logic [1:0] sz, logic sg,
                       logic [31:0] a, logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int unsigned nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    er = (nb == 0) || ((a % nb) != 0) ||
         ((64'(a) + 64'(nb)) > 64'd1024);
    rd = 32'd0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < int'(nb); i++)
          mm[k][a + i] = 8'(wd >> (8 * (int'(nb) - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(nb); i++)
          v = (v << 8) | 32'(mm[k][a + i]);
        if (sg && nb < 4 && v[8*nb-1])
          v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endtask

  // Present a request, wait for rsp_valid; lat counts edges from the
  // accepting edge (inclusive) to the one raising rsp_valid.
  task automatic start(int k, logic wr, logic [1:0] sz, logic sg,
                       logic [31:0] a, logic [31:0] wd,
                       output int lat);
    req_write[k]  = wr;
    req_size[k]   = sz;
    req_signed[k] = sg;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    req_valid[k]  = 1'b1;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish(int k, string tag);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    check({tag, "/ready_after"}, 32'(req_ready[k]), 32'd1);
    check({tag, "/valid_after"}, 32'(rsp_valid[k]), 32'd0);
  endtask

  task automatic run(int k, logic wr, logic [1:0] sz, logic sg,
                     logic [31:0] a, logic [31:0] wd, string tag,
                     bit lit, logic [31:0] lrd, logic ler);
    logic [31:0] erd;
    logic        eer;
    int          lat;
    model(k, wr, sz, sg, a, wd, erd, eer);
    if (lit) begin
      erd = lrd;
      eer = ler;
    end
    check({tag, "/ready_before"}, 32'(req_ready[k]), 32'd1);
    start(k, wr, sz, sg, a, wd, lat);
    check({tag, "/latency"}, 32'(lat), 32'(wc(k) + 1));
    check({tag, "/rdata"}, rsp_rdata[k], erd);
    check({tag, "/err"}, 32'(rsp_err[k]), 32'(eer));
    finish(k, tag);
  endtask

  logic [31:0] erd;
  logic        eer;
  int          lat;
  logic [31:0] ra;
  int          sel;

  initial begin
    rst        = 3'b111;
    req_valid  = '0;
    req_write  = '0;
    req_signed = '0;
    rsp_ready  = '0;
    for (int k = 0; k < 3; k++) begin
      req_size[k]  = 2'd0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset/req_ready", 32'(req_ready[k]), 32'd1);
      check("reset/rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("reset/rsp_rdata", rsp_rdata[k], 32'd0);
      check("reset/rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    rst = 3'b000;
    @(posedge clk);
    #1;

    // Directed sequence on the one-wait-state instance.
    run(1, 1, 2'd2, 0, 32'h10, 32'h1122_3344, "st_w10", 1, 32'd0, 0);
    run(1, 0, 2'd2, 0, 32'h10, 32'h0, "ld_w10", 1, 32'h1122_3344, 0);
    run(1, 0, 2'd0, 0, 32'h11, 32'h0, "ld_b11", 1, 32'h0000_0022, 0);
    run(1, 1, 2'd2, 0, 32'h20, 32'h80FF_7F01, "st_w20", 1, 32'd0, 0);
    run(1, 0, 2'd0, 1, 32'h20, 32'h0, "ld_sb20", 1, 32'hFFFF_FF80, 0);
    run(1, 0, 2'd1, 0, 32'h20, 32'h0, "ld_uh20", 1, 32'h0000_80FF, 0);
    run(1, 0, 2'd1, 1, 32'h22, 32'h0, "ld_sh22", 1, 32'h0000_7F01, 0);
    run(1, 1, 2'd2, 0, 32'h21, 32'hAAAA_5555, "st_mis21", 1, 32'd0, 1);
    run(1, 0, 2'd2, 0, 32'h20, 32'h0, "ld_w20_kept", 1, 32'h80FF_7F01, 0);
    run(1, 0, 2'd2, 0, 32'h3FE, 32'h0, "ld_w3fe", 1, 32'd0, 1);
    run(1, 0, 2'd3, 0, 32'h10, 32'h0, "ld_sz3", 1, 32'd0, 1);
    run(1, 0, 2'd0, 0, 32'h400, 32'h0, "ld_b400", 1, 32'd0, 1);

    // Backpressure: response held while rsp_ready stays low.
    model(1, 0, 2'd2, 0, 32'h10, 32'h0, erd, eer);
    start(1, 0, 2'd2, 0, 32'h10, 32'h0, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp/rsp_valid", 32'(rsp_valid[1]), 32'd1);
      check("bp/rsp_rdata", rsp_rdata[1], erd);
      check("bp/req_ready", 32'(req_ready[1]), 32'd0);
    end
    finish(1, "bp");

    // Latency sweep across the three instances.
    for (int k = 0; k < 3; k++) begin
      run(k, 1, 2'd2, 0, 32'h40, 32'h0, "lat_st", 1, 32'd0, 0);
      run(k, 0, 2'd2, 0, 32'h40, 32'h0, "lat_ld", 1, 32'd0, 0);
    end

    // Reset while a store waits: store is dropped.
    req_write[2] = 1'b1;
    req_size[2]  = 2'd2;
    req_addr[2]  = 32'h40;
    req_wdata[2] = 32'hDEAD_BEEF;
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    check("rstw/in_wait_ready", 32'(req_ready[2]), 32'd0);
    rst[2] = 1'b1;
    #1;
    check("rstw/req_ready", 32'(req_ready[2]), 32'd1);
    check("rstw/rsp_valid", 32'(rsp_valid[2]), 32'd0);
    #2;
    rst[2] = 1'b0;
    @(posedge clk);
    #1;
    run(2, 0, 2'd2, 0, 32'h40, 32'h0, "rstw_ld40", 1, 32'd0, 0);

    // Reset while responding to a store: store already committed.
    model(2, 1, 2'd2, 0, 32'h44, 32'hCAFE_F00D, erd, eer);
    start(2, 1, 2'd2, 0, 32'h44, 32'hCAFE_F00D, lat);
    check("rstr/rsp_valid_hi", 32'(rsp_valid[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    check("rstr/rsp_valid_drop", 32'(rsp_valid[2]), 32'd0);
    check("rstr/req_ready", 32'(req_ready[2]), 32'd1);
    #2;
    rst[2] = 1'b0;
    @(posedge clk);
    #1;
    run(2, 0, 2'd2, 0, 32'h44, 32'h0, "rstr_ld44", 1, 32'hCAFE_F00D, 0);

    // Random phase: seed known regions, then mixed accesses vs model.
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 128; a += 4)
        run(k, 1, 2'd2, 0, 32'(a), $urandom, "init", 0, 32'd0, 0);
      for (int a = 32'h3F0; a < 32'h400; a += 4)
        run(k, 1, 2'd2, 0, 32'(a), $urandom, "init_hi", 0, 32'd0, 0);
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)      ra = 32'($urandom_range(0, 127));
        else if (sel < 9) ra = 32'h3F0 + 32'($urandom_range(0, 31));
        else              ra = $urandom;
        run(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ra, $urandom,
            "rand", 0, 32'd0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
